regdst_hazard_ctrl: RTL and testbench
=====================================

// Module: regdst_hazard_ctrl
// PURPOSE
//  Sequences the RegDst destination select (rt vs rd) for the 5-stage pipeline.
//  Tracks the chosen 5-bit destination through EX/MEM/WB and detects load-use hazards.
//  Issues registered forwarding selects for the EX operands and drives the WB write port.
//  Sits beside ID; its stall output holds IF/ID and inserts an EX bubble.
// PARAMETERS
//  REG_W    5   register-address width
//  CNT_W    16  stall performance-counter width
//  ZERO_REG 1   1: register 0 never creates a hazard/forward
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      synchronous reset, active-low
//  id_valid      in   1      instruction present in ID
//  id_rs         in   REG_W  source A address
//  id_rt         in   REG_W  source B address / I-type destination
//  id_rd         in   REG_W  R-type destination
//  id_reg_dst    in   1      1: dest=rd, 0: dest=rt
//  id_reg_write  in   1      instruction writes regfile
//  id_mem_read   in   1      instruction is a load
//  id_uses_rs    in   1      rs is a real operand
//  id_uses_rt    in   1      rt is a real operand
//  flush         in   1      kill ID instruction (branch taken)
//  stall         out  1      hold IF/ID this cycle (combinational)
//  ex_fwd_a      out  2      EX operand A: 00 regfile, 01 WB, 10 MEM
//  ex_fwd_b      out  2      EX operand B: same encoding
//  wb_we         out  1      regfile write enable
//  wb_dst        out  REG_W  regfile write address
//  stall_count   out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): EX/MEM/WB valid=0, ex_fwd_a/b=00, wb_we=0, wb_dst=0, stall_count=0.
//  - Dest select: id_dst = id_reg_dst ? id_rd : id_rt; entry live = id_valid & id_reg_write
//    & (id_dst!=0 | !ZERO_REG).
//  - Stage slots {valid,dst,wr,load} EX->MEM->WB shift every cycle; no external hold.
//  - Match(s,r): slot s valid & wr & dst==r & uses(r) & (r!=0 | !ZERO_REG).
//  - stall = id_valid & !flush & EX.load & (Match(EX,rs) | Match(EX,rt)).
//  - EX loads: stall|flush|!id_valid -> bubble (valid=0, fwd=00); else ID entry.
//  - Forward select, registered into EX with the instruction, per operand:
//    Match(EX non-load) -> 10; else Match(MEM) -> 01; else 00. Youngest producer wins.
//  - WB-stage producer vs ID read: none; regfile is write-first.
//  - Load-use: 1 stall cycle; next cycle load is in MEM -> operand gets 01.
//  - flush beats stall: stall=0, EX bubble, stall_count unchanged.
//  - wb_we/wb_dst are the WB slot (wb_we=WB.valid&WB.wr); latency ID->wb_we is 3 cycles.
//  - stall_count += 1 per stall cycle, saturates at all-ones, never wraps.
//  - Reset mid-operation clears all slots same edge; no write after reset edge.
// TESTING
//  - add $3 (rd) then add uses $3 next -> 2nd in EX has ex_fwd_a=10, stall=0.
//  - addi $5 (rt, reg_dst=0), nop, sub uses $5 as rt -> ex_fwd_b=01.
//  - lw $4 then add $4,.. -> stall=1 one cycle, EX bubble, then ex_fwd_a=01; count=1.
//  - write to $0 then read $0 -> no stall, fwd=00; lw+flush -> stall=0.
//  - Both EX and MEM write $7, read $7 -> 10; stall_count preset near max -> holds at all-ones.
//  - rst_n low while lw in MEM -> wb_we stays 0, all outputs reset next edge.

Source files
------------

// File: rtl/regdst_hazard_ctrl.sv
// RegDst destination select, EX/MEM/WB destination tracking,
// load-use stall detection and registered EX forwarding selects.
module regdst_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic             wb_we,
  output logic [REG_W-1:0] wb_dst,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic             wr;
    logic             ld;
  } slot_t;

  slot_t            r_ex;
  slot_t            r_mem;
  slot_t            r_wb;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_cnt;

  logic [REG_W-1:0] w_id_dst;
  logic             w_id_wr;
  logic             w_ex_a;
  logic             w_ex_b;
  logic             w_mem_a;
  logic             w_mem_b;
  logic             w_stall;
  logic             w_take;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  function automatic logic f_match(
    input slot_t            s,
    input logic [REG_W-1:0] r,
    input logic             uses
  );
    return s.v & s.wr & (s.dst == r) & uses
         & ((r != '0) | !ZERO_REG);
  endfunction

  // destination select, hazard detect and forward select for ID
  always_comb begin
    w_id_dst = id_reg_dst ? id_rd : id_rt;
    w_id_wr  = id_reg_write
             & ((w_id_dst != '0) | !ZERO_REG);
    w_ex_a   = f_match(r_ex, id_rs, id_uses_rs);
    w_ex_b   = f_match(r_ex, id_rt, id_uses_rt);
    w_mem_a  = f_match(r_mem, id_rs, id_uses_rs);
    w_mem_b  = f_match(r_mem, id_rt, id_uses_rt);
    w_stall  = id_valid & !flush & r_ex.ld
             & (w_ex_a | w_ex_b);
    w_take   = id_valid & !flush & !w_stall;
    w_fwd_a  = 2'b00;
    w_fwd_b  = 2'b00;
    if (w_ex_a && !r_ex.ld) w_fwd_a = 2'b10;
    else if (w_mem_a)       w_fwd_a = 2'b01;
    if (w_ex_b && !r_ex.ld) w_fwd_b = 2'b10;
    else if (w_mem_b)       w_fwd_b = 2'b01;
  end

  // stage slots shift every cycle; stall/flush inject a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
    end else begin
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_take) begin
        r_ex.v   <= 1'b1;
        r_ex.dst <= w_id_dst;
        r_ex.wr  <= w_id_wr;
        r_ex.ld  <= id_mem_read;
        r_fwd_a  <= w_fwd_a;
        r_fwd_b  <= w_fwd_b;
      end else begin
        r_ex    <= '0;
        r_fwd_a <= 2'b00;
        r_fwd_b <= 2'b00;
      end
    end
  end

  // saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stall       = w_stall;
  assign ex_fwd_a    = r_fwd_a;
  assign ex_fwd_b    = r_fwd_b;
  assign wb_we       = r_wb.v & r_wb.wr;
  assign wb_dst      = r_wb.dst;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_regdst_hazard_ctrl.sv
// Scoreboard bench for regdst_hazard_ctrl: stimulus queues
// per-cycle expectations, a negedge monitor pops and compares.
module tb_regdst_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_dst;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             flush;
  logic             stall;
  logic [1:0]       ex_fwd_a;
  logic [1:0]       ex_fwd_b;
  logic             wb_we;
  logic [REG_W-1:0] wb_dst;
  logic [CNT_W-1:0] stall_count;

  regdst_hazard_ctrl #(
    .REG_W(REG_W), .CNT_W(CNT_W), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read),
    .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt),
    .flush(flush), .stall(stall),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .wb_we(wb_we), .wb_dst(wb_dst),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    st, fa, fb, we, dst, cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input string f,
                     input logic [31:0] act, input int e);
    if (e >= 0) begin
      checks++;
      if (act !== 32'(e)) begin
        errors++;
        $display("FAIL %s.%s actual=%0d expected=%0d",
                 nm, f, act, e);
      end
    end
  endtask

  // monitor: compare DUT outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "stall", 32'(stall), e.st);
        chk(e.nm, "fwd_a", 32'(ex_fwd_a), e.fa);
        chk(e.nm, "fwd_b", 32'(ex_fwd_b), e.fb);
        chk(e.nm, "wb_we", 32'(wb_we), e.we);
        chk(e.nm, "wb_dst", 32'(wb_dst),
            (e.we == 1) ? e.dst : -1);
        chk(e.nm, "count", 32'(stall_count), e.cnt);
      end
    end
  end

  task automatic cyc(
    input string nm,
    input logic v, input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd,
    input logic rdst, input logic rw, input logic mr,
    input logic urs, input logic urt, input logic fl,
    input int st, input int fa, input int fb,
    input int we, input int dst, input int cnt);
    exp_t e;
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_rd        = rd;
    id_reg_dst   = rdst;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    flush        = fl;
    e.nm = nm; e.st = st; e.fa = fa; e.fb = fb;
    e.we = we; e.dst = dst; e.cnt = cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input string nm,
    input int st, input int fa, input int fb,
    input int we, input int dst, input int cnt);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        st, fa, fb, we, dst, cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
    id_uses_rs = 0; id_uses_rt = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // EX-stage forward of an R-type result
    cyc("add3", 1,1,2,3, 1,1,0,1,1,0, 0,0,0,0,0,0);
    cyc("use3", 1,3,2,6, 1,1,0,1,1,0, 0,0,0,0,0,0);
    nop("fwd_ex", 0,2,0,0,0,0);
    nop("wb3",    0,0,0,1,3,0);
    nop("wb6",    0,0,0,1,6,0);
    // I-type dest in rt, forwarded from MEM
    cyc("addi5", 1,1,5,9, 0,1,0,1,0,0, 0,0,0,0,0,0);
    nop("gap5",  0,0,0,0,0,0);
    cyc("sub5",  1,1,5,8, 1,1,0,1,1,0, 0,0,0,0,0,0);
    nop("fwd_mem", 0,0,1,1,5,0);
    nop("gap6",    0,0,0,0,0,0);
    nop("wb8",     0,0,0,1,8,0);
    // load-use: one stall, bubble, then MEM forward
    cyc("lw4",   1,1,4,0,  0,1,1,1,0,0, 0,0,0,0,0,0);
    cyc("lu_st", 1,4,2,10, 1,1,0,1,1,0, 1,0,0,0,0,0);
    cyc("lu_hd", 1,4,2,10, 1,1,0,1,1,0, 0,0,0,0,0,1);
    nop("lu_fwd", 0,1,0,1,4,1);
    nop("lu_bub", 0,0,0,0,0,1);
    nop("wb10",   0,0,0,1,10,1);
    // $0 never creates a hazard or a write
    cyc("lw0", 1,1,0,0,  0,1,1,1,0,0, 0,0,0,0,0,1);
    cyc("rd0", 1,0,0,11, 1,1,0,1,1,0, 0,0,0,0,0,1);
    nop("z_fwd",  0,0,0,0,0,1);
    nop("z_nowb", 0,0,0,0,0,1);
    // flush beats stall
    cyc("lw12",  1,1,12,0,   0,1,1,1,0,0, 0,0,0,1,11,1);
    cyc("flush", 1,12,12,13, 1,1,0,1,1,1, 0,0,0,0,0,1);
    nop("fl_bub",  0,0,0,0,0,1);
    nop("wb12",    0,0,0,1,12,1);
    nop("fl_nowb", 0,0,0,0,0,1);
    // youngest producer wins
    cyc("add7",  1,1,2,7,  1,1,0,1,1,0, 0,0,0,0,0,1);
    cyc("addi7", 1,1,7,0,  0,1,0,1,0,0, 0,0,0,0,0,1);
    cyc("use7",  1,7,7,14, 1,1,0,1,1,0, 0,0,0,0,0,1);
    nop("young", 0,2,2,1,7,1);
    nop("wb7b",  0,0,0,1,7,1);
    nop("wb14",  0,0,0,1,14,1);
    // counter saturation
    for (int i = 0; i < 8; i++) begin
      cyc("sat_lw", 1,1,4,0, 0,1,1,1,0,0,
          0,(i == 0) ? 0 : 1,0,-1,0,mn(1 + i, 7));
      cyc("sat_st", 1,4,2,10, 1,1,0,1,1,0,
          1,0,0,-1,0,mn(1 + i, 7));
      cyc("sat_hd", 1,4,2,10, 1,1,0,1,1,0,
          0,0,0,-1,0,mn(2 + i, 7));
    end
    nop("sat_n1", 0,1,0,1,4,7);
    nop("sat_n2", 0,0,0,0,0,7);
    nop("sat_n3", 0,0,0,1,10,7);
    // reset while a load sits in MEM
    cyc("rs_lw", 1,1,4,0, 0,1,1,1,0,0, 0,0,0,0,0,7);
    nop("rs_n1", 0,0,0,0,0,7);
    rst_n = 1'b0;
    nop("rs_lo", 0,0,0,0,0,7);
    rst_n = 1'b1;
    nop("rs_a", 0,0,0,0,0,0);
    nop("rs_b", 0,0,0,0,0,0);
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
